// File: rtl/vx_gbar_arb_if.sv
// Interface bundle for the global-barrier arbiter: requester-side channels,
// the single barrier-unit request channel, and the release broadcast.
interface vx_gbar_arb_if #(
  parameter int NUM_REQS = 4,
  parameter int NB_WIDTH = 4,
  parameter int NC_WIDTH = 4
) ();
  logic [NUM_REQS-1:0]          req_valid;
  logic [NUM_REQS*NB_WIDTH-1:0] req_id;
  logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1;
  logic [NUM_REQS*NC_WIDTH-1:0] req_core_id;
  logic [NUM_REQS-1:0]          req_ready;

  logic                         out_req_valid;
  logic [NB_WIDTH-1:0]          out_req_id;
  logic [NC_WIDTH-1:0]          out_req_size_m1;
  logic [NC_WIDTH-1:0]          out_req_core_id;
  logic                         out_req_ready;

  logic                         in_rsp_valid;
  logic [NB_WIDTH-1:0]          in_rsp_id;
  logic [NUM_REQS-1:0]          rsp_valid;
  logic [NB_WIDTH-1:0]          rsp_id;

  modport slave (
    input  req_valid, req_id, req_size_m1, req_core_id,
    output req_ready,
    output out_req_valid, out_req_id, out_req_size_m1, out_req_core_id,
    input  out_req_ready,
    input  in_rsp_valid, in_rsp_id,
    output rsp_valid, rsp_id
  );

  modport master (
    output req_valid, req_id, req_size_m1, req_core_id,
    input  req_ready,
    input  out_req_valid, out_req_id, out_req_size_m1, out_req_core_id,
    output out_req_ready,
    output in_rsp_valid, in_rsp_id,
    input  rsp_valid, rsp_id
  );
endinterface

// File: rtl/vx_gbar_arb.sv
// Round-robin arbiter sharing one global-barrier request channel, with a
// registered release broadcast. Define VX_GBAR_ARB_PERF_EN for perf counters.
module vx_gbar_arb #(
  parameter int NUM_REQS = 4,
  parameter int NB_WIDTH = 4,
  parameter int NC_WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  vx_gbar_arb_if.slave  bus
`ifdef VX_GBAR_ARB_PERF_EN
  ,
  output logic [31:0]   perf_grants,
  output logic [31:0]   perf_stalls
`endif
);
  localparam int PTR_W = $clog2(NUM_REQS);

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [NB_WIDTH-1:0] out_id_q, out_id_d;
  logic [NC_WIDTH-1:0] out_size_q, out_size_d;
  logic [NC_WIDTH-1:0] out_core_q, out_core_d;
  logic [NUM_REQS-1:0] rsp_valid_q, rsp_valid_d;
  logic [NB_WIDTH-1:0] rsp_id_q, rsp_id_d;

  logic [NUM_REQS-1:0] grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                found;
  logic                can_load;
  logic                hs;
  int                  idx;

  // First valid requester found walking upward from rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQS;
      if (!found && bus.req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  assign can_load      = !out_valid_q || bus.out_req_ready;
  assign hs            = found && can_load;
  assign bus.req_ready = grant & {NUM_REQS{can_load}};

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_size_d  = out_size_q;
    out_core_d  = out_core_q;
    if (hs) begin
      out_valid_d = 1'b1;
      out_id_d    = bus.req_id[grant_idx*NB_WIDTH +: NB_WIDTH];
      out_size_d  = bus.req_size_m1[grant_idx*NC_WIDTH +: NC_WIDTH];
      out_core_d  = bus.req_core_id[grant_idx*NC_WIDTH +: NC_WIDTH];
      rr_ptr_d    = (int'(grant_idx) == NUM_REQS-1) ? '0 : grant_idx + 1'b1;
    end else if (bus.out_req_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = {NUM_REQS{bus.in_rsp_valid}};
    rsp_id_d    = bus.in_rsp_valid ? bus.in_rsp_id : rsp_id_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_size_q  <= '0;
      out_core_q  <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_size_q  <= out_size_d;
      out_core_q  <= out_core_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.out_req_valid   = out_valid_q;
  assign bus.out_req_id      = out_id_q;
  assign bus.out_req_size_m1 = out_size_q;
  assign bus.out_req_core_id = out_core_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_id          = rsp_id_q;

`ifdef VX_GBAR_ARB_PERF_EN
  logic [31:0] grants_q, grants_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    grants_d = grants_q + {31'd0, hs};
    stalls_d = stalls_q + {31'd0, out_valid_q && !bus.out_req_ready};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      grants_q <= grants_d;
      stalls_q <= stalls_d;
    end
  end

  assign perf_grants = grants_q;
  assign perf_stalls = stalls_q;
`endif
endmodule

// File: tb/tb_vx_gbar_arb.sv
// Directed plus randomized bench for vx_gbar_arb against a rotating-priority
// reference model.
module tb_vx_gbar_arb;
  localparam int N  = 4;
  localparam int NB = 4;
  localparam int NC = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  vx_gbar_arb_if #(.NUM_REQS(N), .NB_WIDTH(NB), .NC_WIDTH(NC)) bus ();

`ifdef VX_GBAR_ARB_PERF_EN
  logic [31:0] perf_grants, perf_stalls;
  vx_gbar_arb #(.NUM_REQS(N), .NB_WIDTH(NB), .NC_WIDTH(NC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .perf_grants(perf_grants), .perf_stalls(perf_stalls));
`else
  vx_gbar_arb #(.NUM_REQS(N), .NB_WIDTH(NB), .NC_WIDTH(NC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
`endif

  int checks = 0;
  int passed = 0;

  // Reference model state: priority origin, output slot, release register.
  int          m_ptr;
  bit          m_ov;
  int          m_id, m_sz, m_cid;
  bit          m_rv;
  int          m_rid;
  int unsigned m_grants, m_stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_ov = 0; m_id = 0; m_sz = 0; m_cid = 0;
    m_rv = 0; m_rid = 0; m_grants = 0; m_stalls = 0;
  endtask

  task automatic check_outputs();
    chk("out_req_valid",   32'(bus.out_req_valid),   32'(m_ov));
    chk("out_req_id",      32'(bus.out_req_id),      32'(m_id));
    chk("out_req_size_m1", 32'(bus.out_req_size_m1), 32'(m_sz));
    chk("out_req_core_id", 32'(bus.out_req_core_id), 32'(m_cid));
    chk("rsp_valid",       32'(bus.rsp_valid),       m_rv ? 32'((1 << N) - 1) : 32'd0);
    chk("rsp_id",          32'(bus.rsp_id),          32'(m_rid));
`ifdef VX_GBAR_ARB_PERF_EN
    chk("perf_grants", perf_grants, m_grants);
    chk("perf_stalls", perf_stalls, m_stalls);
`endif
  endtask

  // One clock: check ready against the model, cross the edge, advance model, check outputs.
  task automatic cycle();
    int best, bestd, d;
    bit can, hs, ordy, rv;
    int rid, nid, nsz, ncid;
    logic [N-1:0] er;
    #2;
    best = -1; bestd = N;
    for (int i = 0; i < N; i++)
      if (bus.req_valid[i]) begin
        d = (i - m_ptr + N) % N;
        if (d < bestd) begin bestd = d; best = i; end
      end
    ordy = bus.out_req_ready;
    can  = !m_ov || ordy;
    hs   = (best >= 0) && can;
    er   = '0;
    nid = 0; nsz = 0; ncid = 0;
    if (hs) begin
      er[best] = 1'b1;
      nid  = int'(bus.req_id[best*NB +: NB]);
      nsz  = int'(bus.req_size_m1[best*NC +: NC]);
      ncid = int'(bus.req_core_id[best*NC +: NC]);
    end
    rv  = bus.in_rsp_valid;
    rid = int'(bus.in_rsp_id);
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    @(posedge clk);
    #1;
    if (m_ov && !ordy) m_stalls++;
    if (hs) begin
      m_ov = 1; m_id = nid; m_sz = nsz; m_cid = ncid;
      m_ptr = (best + 1) % N;
      m_grants++;
    end else if (ordy) begin
      m_ov = 0;
    end
    m_rv = rv;
    if (rv) m_rid = rid;
    check_outputs();
  endtask

  task automatic set_req(input int i, input bit v, input int id, input int sz, input int cid);
    bus.req_valid[i]            = v;
    bus.req_id[i*NB +: NB]      = NB'(id);
    bus.req_size_m1[i*NC +: NC] = NC'(sz);
    bus.req_core_id[i*NC +: NC] = NC'(cid);
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = '0; bus.req_id = '0; bus.req_size_m1 = '0; bus.req_core_id = '0;
    bus.out_req_ready = 1'b0; bus.in_rsp_valid = 1'b0; bus.in_rsp_id = '0;
    model_reset();
    #1 reset_n = 1'b0;
    #11;
    check_outputs();
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset mid-stream with a buffered request
    set_req(1, 1, 5, 7, 3);
    bus.out_req_ready = 1'b0;
    bus.in_rsp_valid = 1'b1; bus.in_rsp_id = 4'd6;
    cycle();
    bus.in_rsp_valid = 1'b0;
    cycle();
    chk("pre_reset_valid", 32'(bus.out_req_valid), 32'd1);
    clear_reqs();
    do_reset();

    // Req 2 first after reset, then wrap through 3 -> 0
    bus.out_req_ready = 1'b1;
    set_req(2, 1, 2, 1, 2);
    cycle();
    chk("req2_id", 32'(bus.out_req_id), 32'd2);
    clear_reqs();
    set_req(0, 1, 10, 4, 0);
    set_req(3, 1, 13, 5, 3);
    cycle();
    chk("wrap_req3", 32'(bus.out_req_id), 32'd13);
    cycle();
    chk("wrap_req0", 32'(bus.out_req_id), 32'd10);
    clear_reqs();
    cycle();

    // Fairness with all requesters valid
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, i, i, i);
    bus.out_req_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      cycle();
      chk("fair_order", 32'(bus.out_req_id), 32'(c % N));
    end
    clear_reqs();
    cycle();

    // Backpressure
    set_req(1, 1, 5, 7, 3);
    bus.out_req_ready = 1'b0;
    cycle();
    clear_reqs();
    for (int c = 0; c < 3; c++) cycle();
    chk("bp_id", 32'(bus.out_req_id), 32'd5);
    chk("bp_core", 32'(bus.out_req_core_id), 32'd3);
    chk("bp_size", 32'(bus.out_req_size_m1), 32'd7);
    bus.out_req_ready = 1'b1;
    cycle();

    // Response broadcast alongside a request
    set_req(0, 1, 4, 2, 1);
    bus.in_rsp_valid = 1'b1; bus.in_rsp_id = 4'd9;
    cycle();
    chk("bcast_valid", 32'(bus.rsp_valid), 32'hF);
    clear_reqs();
    bus.in_rsp_valid = 1'b0;
    cycle();

    // Sparse single requester
    for (int c = 0; c < 6; c++) begin
      set_req(0, 1, int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)));
      cycle();
      clear_reqs();
      cycle();
    end

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, bit'($urandom_range(1)), int'($urandom_range(15)),
                int'($urandom_range(15)), int'($urandom_range(15)));
      bus.out_req_ready = ($urandom_range(3) != 0);
      bus.in_rsp_valid  = ($urandom_range(3) == 0);
      bus.in_rsp_id     = NB'($urandom_range(15));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
